// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: FSM state
// encodings for the framing FSM and the byte receiver, plus the frame header.
package imem_uart_loader_pkg;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_CNT  = 3'd1,
      ST_GET_DATA = 3'd2,
      ST_GET_SUM  = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERR      = 3'd5
   } loaderState_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rxState_t;

endpackage

// File: rtl/imem_uart_loader_uart_rx_8n1.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection at
// half a bit, LSB-first data sampling at bit centres, stop-bit framing check.
//
// Output handshake: rx_valid / rx_ferr are single-cycle pulses with no
// backpressure; rx_byte is valid in the rx_valid cycle and the consumer must
// take it in that cycle. rx_valid and rx_ferr are never high together.
module uart_rx_8n1
   import imem_uart_loader_pkg::*;
#(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr,
   output rxState_t   rxState
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV + 1);

   rxState_t         state;
   rxState_t         nextState;
   logic             rxMeta;
   logic             rxSync;
   logic             rxPrev;
   logic [CNT_W-1:0] bitCnt;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;
   logic             halfTick;
   logic             fullTick;
   logic             startEdge;

   assign halfTick  = (bitCnt == CNT_W'(HALF - 1));
   assign fullTick  = (bitCnt == CNT_W'(DIV - 1));
   assign startEdge = rxPrev & ~rxSync;

   // Synchronise the asynchronous line; flops reset to the idle (high) level
   // so leaving reset never looks like a start edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   // Receiver state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= RX_IDLE;
      else        state <= nextState;
   end

   // Next-state: start edge, half-bit glitch check, 8 data bits, stop bit.
   always_comb begin
      nextState = state;
      case (state)
         RX_IDLE:  if (startEdge) nextState = RX_START;
         RX_START: if (halfTick)  nextState = rxSync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (fullTick && (bitIdx == 3'd7)) nextState = RX_STOP;
         RX_STOP:  if (fullTick)  nextState = RX_IDLE;
         default:  nextState = RX_IDLE;
      endcase
   end

   // Bit timing counter, data-bit index and LSB-first shift register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         if ((state == RX_IDLE) || ((state == RX_START) && halfTick) || fullTick)
            bitCnt <= '0;
         else
            bitCnt <= bitCnt + 1'b1;

         if (state != RX_DATA)
            bitIdx <= '0;
         else if (fullTick)
            bitIdx <= bitIdx + 1'b1;

         if ((state == RX_DATA) && fullTick)
            shiftReg <= {rxSync, shiftReg[7:1]};
      end
   end

   // Outputs: pulses at the stop-bit sample point.
   always_comb begin
      rx_byte  = shiftReg;
      rx_valid = (state == RX_STOP) && fullTick && rxSync;
      rx_ferr  = (state == RX_STOP) && fullTick && !rxSync;
      rxState  = state;
   end

endmodule

// File: rtl/imem_uart_loader.sv
// UART instruction-memory loader. Accepts frames of
//   A5, N (0 = 256 words), 4*N data bytes MSB-first, XOR checksum
// writes big-endian words to IMem from word address 0 upward and holds the
// CPU in reset until a frame with a matching checksum completes.
// Optional build macro LOADER_TIMEOUT_EN: an inter-byte gap longer than
// TIMEOUT_CYCLES during a load aborts it to the error state.
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int CLK_HZ         = 100000000,
   parameter int BAUD           = 115200,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              uart_rx,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output loaderState_t      dbgState,
   output rxState_t          dbgRxState
);

   loaderState_t state;
   loaderState_t nextState;
   logic [7:0]   rxByte;
   logic         rxValid;
   logic         rxFerr;
   logic [8:0]   remaining;
   logic [1:0]   byteIdx;
   logic [23:0]  asmWord;
   logic [7:0]   xorAcc;
   logic         startLoad;
   logic         weNext;
   logic         timeout;

   uart_rx_8n1 #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) uRx (
      .Clk      (Clk),
      .Reset    (Reset),
      .rx       (uart_rx),
      .rx_byte  (rxByte),
      .rx_valid (rxValid),
      .rx_ferr  (rxFerr),
      .rxState  (dbgRxState)
   );

   // A header restarts a load only from IDLE or ERR; mid-frame it is data.
   assign startLoad = rxValid && (rxByte == HEADER_BYTE) &&
                      ((state == ST_IDLE) || (state == ST_ERR));
   assign weNext    = (state == ST_GET_DATA) && rxValid && (byteIdx == 2'd3);

`ifdef LOADER_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [GAP_W-1:0] gapCnt;
   logic             gapActive;

   assign gapActive = (state == ST_GET_CNT) || (state == ST_GET_DATA) ||
                      (state == ST_GET_SUM);
   assign timeout   = gapActive && (gapCnt == GAP_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte gap counter; restarts on every received byte and on load start.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                                 gapCnt <= '0;
      else if (rxValid || startLoad || !gapActive) gapCnt <= '0;
      else                                        gapCnt <= gapCnt + 1'b1;
   end
`else
   logic unusedTimeoutCfg;

   assign timeout          = 1'b0;
   assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
`endif

   // Framing FSM state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Next-state: header, count, data words, checksum; framing errors and
   // gap timeouts abort an in-progress load.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (startLoad) nextState = ST_GET_CNT;
         ST_GET_CNT: begin
            if (rxFerr || timeout) nextState = ST_ERR;
            else if (rxValid)      nextState = ST_GET_DATA;
         end
         ST_GET_DATA: begin
            if (rxFerr || timeout)                  nextState = ST_ERR;
            else if (im_we && (remaining == 9'd1))  nextState = ST_GET_SUM;
         end
         ST_GET_SUM: begin
            if (rxFerr || timeout) nextState = ST_ERR;
            else if (rxValid)      nextState = (rxByte == xorAcc) ? ST_DONE : ST_ERR;
         end
         ST_DONE: nextState = ST_IDLE;
         ST_ERR:  if (startLoad) nextState = ST_GET_CNT;
         default: nextState = ST_IDLE;
      endcase
   end

   // Datapath: word assembly, checksum, word counter and the IMem write port.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         remaining <= '0;
         byteIdx   <= '0;
         asmWord   <= '0;
         xorAcc    <= '0;
      end else begin
         im_we <= weNext;

         // Address advances the cycle after each write, including the last,
         // so a 256-word load leaves it wrapped back to 0.
         if (startLoad)  im_addr <= '0;
         else if (im_we) im_addr <= im_addr + 1'b1;

         if ((state == ST_GET_CNT) && rxValid)
            remaining <= (rxByte == 8'd0) ? 9'd256 : {1'b0, rxByte};
         else if (im_we)
            remaining <= remaining - 9'd1;

         if (startLoad) begin
            xorAcc  <= '0;
            byteIdx <= '0;
         end else if ((state == ST_GET_DATA) && rxValid) begin
            xorAcc  <= xorAcc ^ rxByte;
            byteIdx <= byteIdx + 1'b1;
            asmWord <= {asmWord[15:0], rxByte};
            if (byteIdx == 2'd3)
               im_wdata <= {asmWord, rxByte};
         end
      end
   end

   // Outputs decoded from the framing state; the error flag stays up until a
   // new header moves the FSM out of ERR.
   always_comb begin
      cpu_hold  = (state == ST_GET_CNT) || (state == ST_GET_DATA) ||
                  (state == ST_GET_SUM) || (state == ST_ERR);
      load_done = (state == ST_DONE);
      load_err  = (state == ST_ERR);
      dbgState  = state;
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives 8N1 frames on uart_rx, queues the
// expected IMem writes and load_done pulses, and a monitor compares every
// write / done event against the queue. Flag checks are made after frames.
module tb_imem_uart_loader;
   import imem_uart_loader_pkg::*;

   localparam int CLK_HZ         = 600;
   localparam int BAUD           = 100;
   localparam int DIV            = CLK_HZ / BAUD;
   localparam int ADDR_W         = 8;
   localparam int TIMEOUT_CYCLES = 1000;

   logic              Clk     = 1'b0;
   logic              Reset   = 1'b0;
   logic              uart_rx = 1'b1;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   loaderState_t      dbgState;
   rxState_t          dbgRxState;

   int errors = 0;
   int checks = 0;

   // Event encoding: {isDone, addr, data}
   logic [40:0] expQ[$];
   logic [7:0]  txQ[$];

   imem_uart_loader #(
      .CLK_HZ         (CLK_HZ),
      .BAUD           (BAUD),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .uart_rx    (uart_rx),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .dbgState   (dbgState),
      .dbgRxState (dbgRxState)
   );

   // Clock
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkEvent(input string name, input logic [40:0] ev);
      logic [40:0] exp;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("FAIL %s: got event %h expected none", name, ev);
      end else begin
         exp = expQ.pop_front();
         if (ev !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, ev, exp);
         end
      end
   endtask

   // Monitor: every write strobe and done pulse must match the queue head.
   always @(negedge Clk) begin
      if (Reset) begin
         if (im_we)     checkEvent("imem_write", {1'b0, im_addr, im_wdata});
         if (load_done) checkEvent("load_done", {1'b1, 40'h0});
      end
   end

   task automatic pushWrite(input logic [7:0] addr, input logic [31:0] data);
      expQ.push_back({1'b0, addr, data});
   endtask

   task automatic pushDone();
      expQ.push_back({1'b1, 40'h0});
   endtask

   // One 8N1 character; called and returns on a falling clock edge.
   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge Clk);
      end
      uart_rx = stopBit;
      repeat (DIV) @(negedge Clk);
      if (!stopBit) begin
         uart_rx = 1'b1;
         repeat (DIV) @(negedge Clk);
      end
   endtask

   task automatic sendQueue();
      foreach (txQ[i]) sendByte(txQ[i], 1'b1);
      txQ.delete();
   endtask

   task automatic settle();
      repeat (8) @(negedge Clk);
   endtask

   initial begin
      logic [31:0] word;
      logic [7:0]  sum;

      // Reset values
      repeat (3) @(negedge Clk);
      check("rst_im_we", im_we, 0);
      check("rst_im_addr", im_addr, 0);
      check("rst_im_wdata", im_wdata, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_load_done", load_done, 0);
      check("rst_load_err", load_err, 0);
      check("rst_state", dbgState, ST_IDLE);
      Reset = 1'b1;
      repeat (4) @(negedge Clk);

      // Two-word frame; XOR of 12 34 56 78 9A BC DE F0 is 0x00
      txQ = '{8'hA5, 8'h02};
      sendQueue();
      check("hold_during_load", cpu_hold, 1);
      check("err_during_load", load_err, 0);
      pushWrite(8'd0, 32'h12345678);
      pushWrite(8'd1, 32'h9ABCDEF0);
      pushDone();
      txQ = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      sendQueue();
      settle();
      check("f1_cpu_hold", cpu_hold, 0);
      check("f1_load_err", load_err, 0);
      check("f1_im_addr", im_addr, 2);
      check("f1_queue_empty", expQ.size(), 0);

      // Same frame, wrong checksum: words still written, no done, error
      pushWrite(8'd0, 32'h12345678);
      pushWrite(8'd1, 32'h9ABCDEF0);
      txQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h88};
      sendQueue();
      settle();
      check("bad_sum_err", load_err, 1);
      check("bad_sum_hold", cpu_hold, 1);
      check("bad_sum_state", dbgState, ST_ERR);

      // Resend the correct frame from ERR
      pushWrite(8'd0, 32'h12345678);
      pushWrite(8'd1, 32'h9ABCDEF0);
      pushDone();
      txQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      sendQueue();
      settle();
      check("resend_err", load_err, 0);
      check("resend_hold", cpu_hold, 0);

      // Leading junk ignored; DE^AD^BE^EF = 0x22
      pushWrite(8'd0, 32'hDEADBEEF);
      pushDone();
      txQ = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      sendQueue();
      settle();
      check("junk_hold", cpu_hold, 0);
      check("junk_err", load_err, 0);

      // Header value inside data is data; A5^00^00^01 = 0xA4
      pushWrite(8'd0, 32'hA5000001);
      pushDone();
      txQ = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
      sendQueue();
      settle();
      check("a5_data_err", load_err, 0);

      // N=0: 256 words of incrementing bytes; address wraps to 0
      txQ = '{8'hA5, 8'h00};
      sum = 8'h00;
      for (int k = 0; k < 256; k++) begin
         word = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
         pushWrite(8'(k), word);
         for (int j = 0; j < 4; j++) begin
            txQ.push_back(8'(4*k+j));
            sum = sum ^ 8'(4*k+j);
         end
      end
      txQ.push_back(sum);
      pushDone();
      sendQueue();
      settle();
      check("n256_addr_wrap", im_addr, 0);
      check("n256_hold", cpu_hold, 0);
      check("n256_err", load_err, 0);

      // Framing error on the third data byte
      txQ = '{8'hA5, 8'h02, 8'h11, 8'h22};
      sendQueue();
      sendByte(8'h33, 1'b0);
      settle();
      check("ferr_err", load_err, 1);
      check("ferr_hold", cpu_hold, 1);
      txQ = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      sendQueue();
      settle();
      check("ferr_still_err", load_err, 1);
      check("ferr_no_writes", expQ.size(), 0);

      // Reset in the middle of GET_DATA after one word is written
      pushWrite(8'd0, 32'h01020304);
      txQ = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      sendQueue();
      check("mid_state", dbgState, ST_GET_DATA);
      check("mid_addr", im_addr, 1);
      #2 Reset = 1'b0;
      #1;
      check("async_im_we", im_we, 0);
      check("async_im_addr", im_addr, 0);
      check("async_im_wdata", im_wdata, 0);
      check("async_cpu_hold", cpu_hold, 0);
      check("async_load_done", load_done, 0);
      check("async_load_err", load_err, 0);
      check("async_state", dbgState, ST_IDLE);
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      settle();
      check("post_rst_hold", cpu_hold, 0);

`ifdef LOADER_TIMEOUT_EN
      // Stall after the count byte; abort after TIMEOUT_CYCLES
      txQ = '{8'hA5, 8'h01};
      sendQueue();
      repeat (TIMEOUT_CYCLES - 20) @(negedge Clk);
      check("to_before_err", load_err, 0);
      check("to_before_state", dbgState, ST_GET_DATA);
      repeat (40) @(negedge Clk);
      check("to_after_err", load_err, 1);
      check("to_after_hold", cpu_hold, 1);
`endif

      settle();
      check("queue_drained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
